// File: rtl/number_compare.sv
// ---------------------------------------------------------------------------
// number_compare
//
// Registered magnitude comparator. Each cycle with in_valid high, A and B are
// compared and the one-hot relation code plus the larger/smaller operand are
// registered. The result appears one cycle later with out_valid. When in_valid
// is low, out_valid drops and the result registers hold their last value.
//
// Parameters:
//   WIDTH        operand width in bits (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     A/B are valid this cycle
//   A, B         operands
//   signed_mode  (NUMBER_COMPARE_SIGNED_EN only) 1 = two's complement compare
//   Y            one-hot relation: [2] A>B, [1] A==B, [0] A<B
//   out_valid    Y/max_out/min_out hold a fresh result
//   max_out      larger operand (A when equal)
//   min_out      smaller operand (B when equal)
//
// Optional feature macro: NUMBER_COMPARE_SIGNED_EN adds the signed_mode input.
// ---------------------------------------------------------------------------
module number_compare #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef NUMBER_COMPARE_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic [2:0]       Y,
    output logic             out_valid,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out
);

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             a_gt;
    logic             a_eq;
    logic             a_lt;
    logic [2:0]       y_next;
    logic [WIDTH-1:0] max_next;
    logic [WIDTH-1:0] min_next;

    // Inverting the MSB of both operands maps two's complement ordering onto
    // unsigned ordering, so a single unsigned comparator serves both modes.
    always_comb begin
        a_key = A;
        b_key = B;
`ifdef NUMBER_COMPARE_SIGNED_EN
        if (signed_mode) begin
            a_key[WIDTH-1] = ~A[WIDTH-1];
            b_key[WIDTH-1] = ~B[WIDTH-1];
        end
`endif
    end

    always_comb begin
        a_gt     = (a_key > b_key);
        a_eq     = (a_key == b_key);
        a_lt     = (a_key < b_key);
        y_next   = {a_gt, a_eq, a_lt};
        // Ties resolve to max=A, min=B.
        max_next = a_lt ? B : A;
        min_next = a_lt ? A : B;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y         <= 3'b000;
            out_valid <= 1'b0;
            max_out   <= '0;
            min_out   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Y       <= y_next;
                max_out <= max_next;
                min_out <= min_next;
            end
        end
    end

endmodule

// File: tb/tb_number_compare.sv
module tb_number_compare;

    localparam int W = 4;

    typedef struct {
        logic [2:0]   y;
        logic [W-1:0] mx;
        logic [W-1:0] mn;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a_drv;
    logic [W-1:0] b_drv;
    logic         sm_drv;
    logic [2:0]   y;
    logic         out_valid;
    logic [W-1:0] max_out;
    logic [W-1:0] min_out;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];
    logic exp_valid;
    exp_t held;

    number_compare #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .A          (a_drv),
        .B          (b_drv),
`ifdef NUMBER_COMPARE_SIGNED_EN
        .signed_mode(sm_drv),
`endif
        .Y          (y),
        .out_valid  (out_valid),
        .max_out    (max_out),
        .min_out    (min_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: order the operands as plain integers, then pick the code.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        exp_t e;
        int av;
        int bv;
        av = int'(a);
        bv = int'(b);
        if (sm) begin
            if (av >= (1 << (W - 1))) av = av - (1 << W);
            if (bv >= (1 << (W - 1))) bv = bv - (1 << W);
        end
        if (av > bv)       e.y = 3'b100;
        else if (av == bv) e.y = 3'b010;
        else               e.y = 3'b001;
        e.mx = (av >= bv) ? a : b;
        e.mn = (av >= bv) ? b : a;
        return e;
    endfunction

    // Predictor: records what the DUT must present after each capture edge.
    always @(posedge clk) begin
        if (rst_n) begin
            exp_valid = in_valid;
            if (in_valid === 1'b1) begin
`ifdef NUMBER_COMPARE_SIGNED_EN
                exp_q.push_back(model(a_drv, b_drv, sm_drv));
`else
                exp_q.push_back(model(a_drv, b_drv, 1'b0));
`endif
            end
        end
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        exp_valid = 1'b0;
        held.y  = 3'b000;
        held.mx = '0;
        held.mn = '0;
    end

    // Monitor: pops one expected result whenever the DUT flags a fresh one,
    // otherwise demands that the last result is held.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard: result with no expected entry at %0t", $time);
                end else begin
                    held = exp_q.pop_front();
                end
            end
            check("Y", {29'd0, y}, {29'd0, held.y});
            check("max_out", {28'd0, max_out}, {28'd0, held.mx});
            check("min_out", {28'd0, min_out}, {28'd0, held.mn});
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic v, input logic sm);
        @(negedge clk);
        in_valid = v;
        a_drv    = a;
        b_drv    = b;
        sm_drv   = sm;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_Y"}, {29'd0, y}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_max_out"}, {28'd0, max_out}, 32'd0);
        check({tag, "_min_out"}, {28'd0, min_out}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_drv    = '0;
        b_drv    = '0;
        sm_drv   = 1'b0;
        #2;
        check_reset_values("reset_initial");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive('0, '0, 1'b0, 1'b0);

        // Directed sequence
        drive(4'b0001, 4'b0001, 1'b1, 1'b0);
        drive(4'b0001, 4'b0010, 1'b1, 1'b0);
        drive(4'b0100, 4'b0001, 1'b1, 1'b0);
        drive(4'b1110, 4'b1101, 1'b1, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 4'b1111, 1'b1, 1'b0);
        drive(4'b1111, 4'b1111, 1'b1, 1'b0);
        drive(4'b1000, 4'b0111, 1'b1, 1'b1);
        drive(4'b1000, 4'b0111, 1'b1, 1'b0);
        drive(4'b0111, 4'b1000, 1'b1, 1'b1);
        drive(4'b1111, 4'b0000, 1'b1, 1'b1);

        // Mid-cycle asynchronous reset with a result in flight
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        drive('0, '0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);

        // Random traffic, with undriven operands while idle
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rv;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: begin ra = '1; rb = '0; end
                2: begin ra = '0; rb = '1; end
                default: ;
            endcase
            rv = ($urandom_range(0, 3) != 0);
            rs = 1'($urandom);
            if (!rv) begin
                ra = 'x;
                rb = 'x;
            end
            drive(ra, rb, rv, rs);
        end

        drive('0, '0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
